multimode_decimator: RTL and testbench

//  Multi-channel decimator for the acquisition path, sitting between the ADC capture stage and the sample buffer.

---
 rtl/multimode_decimator_pkg.sv | 18 +
 rtl/multimode_decimator_channel.sv | 71 +++++++
 rtl/multimode_decimator.sv | 104 ++++++++++
 tb/tb_multimode_decimator.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/multimode_decimator_pkg.sv
// Shared definitions for the multimode decimator.
//  - mode_e  : decimation mode codes (SAMPLE, AVERAGE, PEAK_MAX, PEAK_MIN)
//  - clamp_k : limits a requested log2(DF) to the largest value the
//              accumulator width can hold without overflow.
package multimode_decimator_pkg;

  typedef enum logic [1:0] {
    MODE_SAMPLE   = 2'd0,
    MODE_AVERAGE  = 2'd1,
    MODE_PEAK_MAX = 2'd2,
    MODE_PEAK_MIN = 2'd3
  } mode_e;

  function automatic int unsigned clamp_k(input int unsigned k_in, input int unsigned max_k);
    return (k_in > max_k) ? max_k : k_in;
  endfunction

endpackage

// File: rtl/multimode_decimator_channel.sv
// decim_channel: one channel's accumulator / peak registers and result mux.
// Ports:
//  clk, rst     clock, synchronous active-high reset
//  en           a sample is consumed this cycle
//  first, last  the consumed sample opens / closes the frame
//  mode_q, k_q  latched frame configuration
//  sample       this channel's input sample
//  result       registered decimated output, held between frames
module decim_channel
  import multimode_decimator_pkg::*;
#(
  parameter int BITS_ADC  = 8,
  parameter int BITS_ACUM = 12,
  parameter int KW        = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                first,
  input  logic                last,
  input  mode_e               mode_q,
  input  logic [KW-1:0]       k_q,
  input  logic [BITS_ADC-1:0] sample,
  output logic [BITS_ADC-1:0] result
);

  logic [BITS_ACUM-1:0] acc_q, acc_d, avg;
  logic [BITS_ADC-1:0]  peak_q, peak_d, result_q, result_d;

  always_comb begin
    acc_d    = acc_q;
    peak_d   = peak_q;
    result_d = result_q;
    avg      = '0;
    if (en) begin
      // First sample seeds both registers; peak_q doubles as the held
      // sample in SAMPLE mode, so later samples simply leave it alone.
      if (first) begin
        acc_d  = BITS_ACUM'(sample);
        peak_d = sample;
      end else begin
        case (mode_q)
          MODE_AVERAGE:  acc_d = acc_q + BITS_ACUM'(sample);
          MODE_PEAK_MAX: if (sample > peak_q) peak_d = sample;
          MODE_PEAK_MIN: if (sample < peak_q) peak_d = sample;
          default:       ;
        endcase
      end
      // Result uses the next-state values so the closing sample counts.
      if (last) begin
        avg      = acc_d >> k_q;
        result_d = (mode_q == MODE_AVERAGE) ? avg[BITS_ADC-1:0] : peak_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      peak_q   <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      peak_q   <= peak_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/multimode_decimator.sv
// multimode_decimator: decimates CHANNELS parallel sample streams by 2^k
// using SAMPLE / AVERAGE / PEAK_MAX / PEAK_MIN reduction.
// Ports:
//  clk, rst    clock, synchronous active-high reset
//  k, mode     requested config, latched at reset, restart and frame end
//  restart     abort the current frame and reload config (drops rdy_in)
//  sample_in   CHANNELS packed samples, ch0 in LSBs, qualified by rdy_in
//  sample_out  decimated samples, ch0 in LSBs, valid with rdy_out
//  rdy_out     one-cycle strobe, 1 clk after the last sample of a frame
module multimode_decimator
  import multimode_decimator_pkg::*;
#(
  parameter  int BITS_ADC  = 8,
  parameter  int BITS_ACUM = 12,
  parameter  int CHANNELS  = 2,
  localparam int MAX_K     = BITS_ACUM - BITS_ADC,
  localparam int KW        = $clog2(MAX_K + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [KW-1:0]                k,
  input  logic [1:0]                   mode,
  input  logic                         restart,
  input  logic [CHANNELS*BITS_ADC-1:0] sample_in,
  input  logic                         rdy_in,
  output logic [CHANNELS*BITS_ADC-1:0] sample_out,
  output logic                         rdy_out
);

  logic [KW-1:0]    k_q, k_d, k_clamp;
  mode_e            mode_q, mode_d;
  logic [MAX_K-1:0] cnt_q, cnt_d, last_cnt;
  logic [MAX_K:0]   df;
  logic             rdy_q, rdy_d;
  logic             accept, first, last;

  assign k_clamp  = KW'(clamp_k(32'(k), MAX_K));
  assign df       = (MAX_K+1)'(1) << k_q;
  assign last_cnt = MAX_K'(df - 1'b1);
  assign first    = (cnt_q == '0);
  assign last     = (cnt_q == last_cnt);
  assign accept   = rdy_in & ~restart;

  always_comb begin
    cnt_d  = cnt_q;
    k_d    = k_q;
    mode_d = mode_q;
    rdy_d  = 1'b0;
    if (restart) begin
      cnt_d  = '0;
      k_d    = k_clamp;
      mode_d = mode_e'(mode);
    end else if (rdy_in) begin
      if (last) begin
        // Frame boundary is the only mid-stream point where config may change.
        cnt_d  = '0;
        k_d    = k_clamp;
        mode_d = mode_e'(mode);
        rdy_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      k_q    <= k_clamp;
      mode_q <= mode_e'(mode);
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      k_q    <= k_d;
      mode_q <= mode_d;
      rdy_q  <= rdy_d;
    end
  end

  assign rdy_out = rdy_q;

  logic [CHANNELS-1:0][BITS_ADC-1:0] ch_in, ch_out;
  assign ch_in      = sample_in;
  assign sample_out = ch_out;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    decim_channel #(
      .BITS_ADC (BITS_ADC),
      .BITS_ACUM(BITS_ACUM),
      .KW       (KW)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .en    (accept),
      .first (first),
      .last  (last),
      .mode_q(mode_q),
      .k_q   (k_q),
      .sample(ch_in[c]),
      .result(ch_out[c])
    );
  end

endmodule

// File: tb/tb_multimode_decimator.sv
// Bench for multimode_decimator (BITS_ADC=8, BITS_ACUM=12, CHANNELS=2).
// A frame-level reference model collects each frame's samples in a queue and
// reduces them with plain arithmetic when the frame is complete.
module tb_multimode_decimator;
  localparam int MAX_K = 4;
  localparam int KW    = 3;

  logic          clk = 1'b0;
  logic          rst, restart, rdy_in, rdy_out;
  logic [KW-1:0] k;
  logic [1:0]    mode;
  logic [15:0]   sample_in, sample_out;

  always #5 clk = ~clk;

  multimode_decimator #(.BITS_ADC(8), .BITS_ACUM(12), .CHANNELS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .k         (k),
    .mode      (mode),
    .restart   (restart),
    .sample_in (sample_in),
    .rdy_in    (rdy_in),
    .sample_out(sample_out),
    .rdy_out   (rdy_out)
  );

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  logic [15:0] fq[$];
  int          cur_k, cur_mode;
  logic        exp_rdy;
  logic [15:0] exp_out;
  int          tk, tm;   // config presented on k/mode

  function automatic int clampk(input int kk);
    return (kk > MAX_K) ? MAX_K : kk;
  endfunction

  function automatic logic [15:0] frame_result();
    logic [15:0] r;
    r = '0;
    for (int c = 0; c < 2; c++) begin
      int sum, mx, mn, v, fst;
      sum = 0; mx = 0; mn = 255;
      fst = int'(fq[0][c*8 +: 8]);
      foreach (fq[i]) begin
        v   = int'(fq[i][c*8 +: 8]);
        sum += v;
        if (v > mx) mx = v;
        if (v < mn) mn = v;
      end
      case (cur_mode)
        0:       v = fst;
        1:       v = sum / (1 << cur_k);
        2:       v = mx;
        default: v = mn;
      endcase
      r[c*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  task automatic model_edge();
    if (rst) begin
      fq.delete(); cur_k = clampk(tk); cur_mode = tm; exp_rdy = 1'b0; exp_out = '0;
    end else if (restart) begin
      fq.delete(); cur_k = clampk(tk); cur_mode = tm; exp_rdy = 1'b0;
    end else if (rdy_in) begin
      fq.push_back(sample_in);
      if (fq.size() == (1 << cur_k)) begin
        exp_out = frame_result(); exp_rdy = 1'b1;
        fq.delete(); cur_k = clampk(tk); cur_mode = tm;
      end else exp_rdy = 1'b0;
    end else exp_rdy = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle at the negedge, advance the model, compare at the next negedge.
  task automatic step(input string tag, input logic r, input logic rs, input logic v, input logic [15:0] s);
    rst = r; restart = rs; rdy_in = v; sample_in = s;
    k = tk[KW-1:0]; mode = tm[1:0];
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check({tag, " rdy_out"}, int'(rdy_out), int'(exp_rdy));
    check({tag, " sample_out"}, int'(sample_out), int'(exp_out));
  endtask

  task automatic feed(input string tag, input logic [15:0] s);
    step(tag, 1'b0, 1'b0, 1'b1, s);
  endtask

  typedef struct {
    logic        rdy;
    logic [15:0] s;
    logic        exp_rdy;
    logic [15:0] exp_out;
  } vec_t;

  vec_t tbl[10];

  initial begin
    rst = 1'b1; restart = 1'b0; rdy_in = 1'b0; sample_in = '0; k = '0; mode = '0;
    tk = 2; tm = 1;
    @(negedge clk);

    // reset state, AVERAGE k=2
    step("reset", 1'b1, 1'b0, 1'b0, 16'h0000);
    check("reset rdy_out const", int'(rdy_out), 0);
    check("reset sample_out const", int'(sample_out), 0);

    // table: two AVERAGE frames, idle gap freezes state, output holds
    tbl[0] = '{1'b1, {8'd1,   8'd10}, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, {8'd2,   8'd20}, 1'b0, 16'h0000};
    tbl[2] = '{1'b1, {8'd3,   8'd30}, 1'b0, 16'h0000};
    tbl[3] = '{1'b1, {8'd4,   8'd41}, 1'b1, {8'd2, 8'd25}};
    tbl[4] = '{1'b0, 16'h0000,        1'b0, {8'd2, 8'd25}};
    tbl[5] = '{1'b1, {8'd7,   8'd200},1'b0, {8'd2, 8'd25}};
    tbl[6] = '{1'b0, 16'hffff,        1'b0, {8'd2, 8'd25}};
    tbl[7] = '{1'b1, {8'd9,   8'd100},1'b0, {8'd2, 8'd25}};
    tbl[8] = '{1'b1, {8'd11,  8'd50}, 1'b0, {8'd2, 8'd25}};
    tbl[9] = '{1'b1, {8'd0,   8'd51}, 1'b1, {8'd6, 8'd100}};
    for (int i = 0; i < 10; i++) begin
      step("tbl", 1'b0, 1'b0, tbl[i].rdy, tbl[i].s);
      check($sformatf("tbl[%0d] rdy_out", i), int'(rdy_out), int'(tbl[i].exp_rdy));
      check($sformatf("tbl[%0d] sample_out", i), int'(sample_out), int'(tbl[i].exp_out));
    end

    // PEAK_MAX k=3 with a 255 glitch on ch1, then a clean frame
    tk = 3; tm = 2;
    step("pk restart", 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 8; i++) feed("pkmax", {(i == 4) ? 8'd255 : 8'(10 + i), 8'(i)});
    check("pkmax glitch", int'(sample_out[15:8]), 255);
    for (int i = 0; i < 8; i++) feed("pkmax2", {8'(20 + i), 8'(i)});
    check("pkmax after glitch", int'(sample_out[15:8]), 27);
    tm = 3;
    step("pkmin restart", 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 8; i++) feed("pkmin", {(i == 5) ? 8'd0 : 8'(60 + i), 8'(90 - i)});
    check("pkmin glitch", int'(sample_out[15:8]), 0);
    for (int i = 0; i < 8; i++) feed("pkmin2", {8'(50 + i), 8'(i)});
    check("pkmin after glitch", int'(sample_out[15:8]), 50);

    // k=0: pass-through at full rate in every mode
    for (int m = 0; m < 4; m++) begin
      tk = 0; tm = m;
      step("k0 restart", 1'b0, 1'b1, 1'b0, 16'h0000);
      for (int i = 0; i < 10; i++) begin
        feed("k0", {8'(i + 100), 8'(i)});
        check("k0 ramp rdy", int'(rdy_out), 1);
        check("k0 ramp value", int'(sample_out), int'({8'(i + 100), 8'(i)}));
      end
    end

    // k change mid-frame applies from the next frame only
    tk = 2; tm = 1;
    step("kchg restart", 1'b0, 1'b1, 1'b0, 16'h0000);
    feed("kchg", 16'h0101); feed("kchg", 16'h0202);
    tk = 4;
    feed("kchg", 16'h0303); feed("kchg", 16'h0404);
    check("kchg closes at 4", int'(rdy_out), 1);
    for (int i = 0; i < 15; i++) feed("kchg16", 16'h1010);
    check("kchg 15 no rdy", int'(rdy_out), 0);
    feed("kchg16", 16'h1010);
    check("kchg closes at 16", int'(rdy_out), 1);

    // restart coincident with the 4th sample drops it; next 4 are a clean frame
    tk = 2; tm = 1;
    step("rs restart", 1'b0, 1'b1, 1'b0, 16'h0000);
    feed("rs", 16'hffff); feed("rs", 16'hffff); feed("rs", 16'hffff);
    step("rs drop", 1'b0, 1'b1, 1'b1, 16'hffff);
    check("rs no rdy", int'(rdy_out), 0);
    feed("rs2", 16'h0404); feed("rs2", 16'h0808); feed("rs2", 16'h0c0c); feed("rs2", 16'h1010);
    check("rs clean frame", int'(sample_out), 16'h0a0a);
    feed("rst mid", 16'h5555); feed("rst mid", 16'h5555);
    step("rst mid", 1'b1, 1'b0, 1'b1, 16'h5555);
    check("rst mid zero", int'(sample_out), 0);

    // AVERAGE at MAX_K with full-scale input, then k=7 clamps to 16-sample frames
    tk = 4; tm = 1;
    step("max restart", 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 16; i++) feed("maxk", 16'hffff);
    check("maxk no overflow", int'(sample_out), 16'hffff);
    tk = 7;
    step("clamp restart", 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 15; i++) feed("clamp", 16'h0f0f);
    check("clamp 15 no rdy", int'(rdy_out), 0);
    feed("clamp", 16'h0f0f);
    check("clamp closes at 16", int'(rdy_out), 1);

    // randomized traffic against the frame model
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if ($urandom_range(0, 19) == 0) tk = int'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) tm = int'($urandom_range(0, 3));
      step("rand", r == 0, (r > 0) && (r < 4), ($urandom_range(0, 3) != 0), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
